// File: rtl/ysyx_2022040010_rw_sched.sv
// Arbiter for the single AXI rw bridge port: icache, dcache, uncache.
// Fixed priority dc > uc > ic; dirty dcache miss runs writeback then refill.
// Optional icache anti-starvation guard: RW_SCHED_STARVE_GUARD_EN.
// Ports: clock/reset; ic_*, dc_*, uc_* requester ports; rw_*, w_mask_o,
//   data_write_o, data_read_i bridge port; stall_o CPU-wide cache stall.
module ysyx_2022040010_rw_sched #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_dirty_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [ADDR_W-1:0] dc_vaddr_i,
  input  logic [DATA_W-1:0] dc_wbdata_i,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_done_o,
  input  logic              uc_req_i,
  input  logic              uc_we_i,
  input  logic [ADDR_W-1:0] uc_addr_i,
  input  logic [1:0]        uc_size_i,
  input  logic [7:0]        uc_mask_i,
  input  logic [DATA_W-1:0] uc_wdata_i,
  output logic [DATA_W-1:0] uc_rdata_o,
  output logic              uc_done_o,
  output logic              rw_valid_o,
  input  logic              rw_ready_i,
  output logic              rw_req_o,
  output logic [ADDR_W-1:0] rw_addr_o,
  output logic [1:0]        rw_size_o,
  output logic [3:0]        rw_id_o,
  input  logic [3:0]        rw_id_i,
  output logic [7:0]        w_mask_o,
  output logic [DATA_W-1:0] data_write_o,
  input  logic [DATA_W-1:0] data_read_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_WB, S_RD, S_DONE
  } state_t;

  localparam logic [3:0] ID_IC = 4'd1;
  localparam logic [3:0] ID_DC = 4'd2;
  localparam logic [3:0] ID_UC = 4'd3;
  localparam logic [ADDR_W-1:0] LINE = ~ADDR_W'(7);

  state_t state, state_nxt;

  logic [3:0]        id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] refill_q;
  logic [1:0]        size_q;
  logic [7:0]        mask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ic_rd_q, dc_rd_q, uc_rd_q;

  logic acc;
  logic force_ic;
  logic gnt_ic, gnt_dc, gnt_uc;

  assign acc = rw_ready_i && (rw_id_i == id_q);

`ifdef RW_SCHED_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_q;

  assign force_ic = ic_req_i && (wait_q == CW'(MAX_WAIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (state == S_IDLE) begin
      if (gnt_ic)
        wait_q <= '0;
      else if ((gnt_dc || gnt_uc) && ic_req_i)
        wait_q <= wait_q + CW'(1);
    end
  end
`else
  // A negative wait limit can never be reached: pure fixed priority.
  assign force_ic = (MAX_WAIT < 0);
`endif

  always_comb begin
    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    gnt_uc = 1'b0;
    if (force_ic)      gnt_ic = 1'b1;
    else if (dc_req_i) gnt_dc = 1'b1;
    else if (uc_req_i) gnt_uc = 1'b1;
    else if (ic_req_i) gnt_ic = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (gnt_dc && dc_dirty_i)
          state_nxt = S_WB;
        else if (gnt_dc || gnt_uc || gnt_ic)
          state_nxt = S_RD;
      end
      S_WB:    if (acc) state_nxt = S_RD;
      S_RD:    if (acc) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      refill_q <= '0;
      size_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      ic_rd_q  <= '0;
      dc_rd_q  <= '0;
      uc_rd_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_ic) begin
            id_q    <= ID_IC;
            we_q    <= 1'b0;
            addr_q  <= ic_addr_i & LINE;
            size_q  <= 2'd3;
            mask_q  <= 8'hFF;
            wdata_q <= '0;
          end else if (gnt_dc) begin
            id_q     <= ID_DC;
            refill_q <= dc_addr_i & LINE;
            size_q   <= 2'd3;
            mask_q   <= 8'hFF;
            we_q     <= dc_dirty_i;
            addr_q   <= dc_dirty_i ? (dc_vaddr_i & LINE)
                                   : (dc_addr_i & LINE);
            wdata_q  <= dc_dirty_i ? dc_wbdata_i : '0;
          end else if (gnt_uc) begin
            id_q    <= ID_UC;
            we_q    <= uc_we_i;
            addr_q  <= uc_addr_i;
            size_q  <= uc_size_i;
            mask_q  <= uc_mask_i;
            wdata_q <= uc_wdata_i;
          end
        end
        S_WB: begin
          // Writeback done: turn the same grant into the refill read.
          if (acc) begin
            we_q    <= 1'b0;
            addr_q  <= refill_q;
            wdata_q <= '0;
          end
        end
        S_RD: begin
          if (acc) begin
            unique case (1'b1)
              (id_q == ID_IC): ic_rd_q <= we_q ? '0 : data_read_i;
              (id_q == ID_DC): dc_rd_q <= we_q ? '0 : data_read_i;
              (id_q == ID_UC): uc_rd_q <= we_q ? '0 : data_read_i;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign rw_valid_o   = (state == S_WB) || (state == S_RD);
  assign rw_req_o     = we_q;
  assign rw_addr_o    = addr_q;
  assign rw_size_o    = size_q;
  assign rw_id_o      = id_q;
  assign w_mask_o     = mask_q;
  assign data_write_o = wdata_q;

  assign ic_done_o = (state == S_DONE) && (id_q == ID_IC);
  assign dc_done_o = (state == S_DONE) && (id_q == ID_DC);
  assign uc_done_o = (state == S_DONE) && (id_q == ID_UC);

  assign ic_rdata_o = ic_rd_q;
  assign dc_rdata_o = dc_rd_q;
  assign uc_rdata_o = uc_rd_q;

  assign stall_o = (ic_req_i && !ic_done_o)
                || (dc_req_i && !dc_done_o)
                || (uc_req_i && !uc_done_o);

endmodule

// File: tb/tb_ysyx_2022040010_rw_sched.sv
// Bench for ysyx_2022040010_rw_sched: bridge responder plus request model.
// Directed scenarios followed by randomized single transactions.
module tb_ysyx_2022040010_rw_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic [63:0] ic_rdata_o;
  logic        ic_done_o;
  logic        dc_req_i;
  logic        dc_dirty_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_vaddr_i;
  logic [63:0] dc_wbdata_i;
  logic [63:0] dc_rdata_o;
  logic        dc_done_o;
  logic        uc_req_i;
  logic        uc_we_i;
  logic [31:0] uc_addr_i;
  logic [1:0]  uc_size_i;
  logic [7:0]  uc_mask_i;
  logic [63:0] uc_wdata_i;
  logic [63:0] uc_rdata_o;
  logic        uc_done_o;
  logic        rw_valid_o;
  logic        rw_ready_i;
  logic        rw_req_o;
  logic [31:0] rw_addr_o;
  logic [1:0]  rw_size_o;
  logic [3:0]  rw_id_o;
  logic [3:0]  rw_id_i;
  logic [7:0]  w_mask_o;
  logic [63:0] data_write_o;
  logic [63:0] data_read_i;
  logic        stall_o;

  always #5 clock = ~clock;

  ysyx_2022040010_rw_sched #(
    .ADDR_W(32), .DATA_W(64), .MAX_WAIT(2)
  ) dut (
    .clock(clock), .reset(reset),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .ic_rdata_o(ic_rdata_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_dirty_i(dc_dirty_i),
    .dc_addr_i(dc_addr_i), .dc_vaddr_i(dc_vaddr_i),
    .dc_wbdata_i(dc_wbdata_i), .dc_rdata_o(dc_rdata_o),
    .dc_done_o(dc_done_o),
    .uc_req_i(uc_req_i), .uc_we_i(uc_we_i), .uc_addr_i(uc_addr_i),
    .uc_size_i(uc_size_i), .uc_mask_i(uc_mask_i),
    .uc_wdata_i(uc_wdata_i), .uc_rdata_o(uc_rdata_o),
    .uc_done_o(uc_done_o),
    .rw_valid_o(rw_valid_o), .rw_ready_i(rw_ready_i),
    .rw_req_o(rw_req_o), .rw_addr_o(rw_addr_o),
    .rw_size_o(rw_size_o), .rw_id_o(rw_id_o), .rw_id_i(rw_id_i),
    .w_mask_o(w_mask_o), .data_write_o(data_write_o),
    .data_read_i(data_read_i), .stall_o(stall_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [3:0]  id;
  } xact_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // What the bridge should see for each requester kind.
  function automatic xact_t line_rd(input logic [31:0] a,
                                    input logic [3:0] id);
    xact_t x;
    x.we = 1'b0; x.addr = a & 32'hFFFF_FFF8; x.size = 2'd3;
    x.mask = 8'hFF; x.wdata = '0; x.id = id;
    return x;
  endfunction

  function automatic xact_t line_wb(input logic [31:0] a,
                                    input logic [63:0] d);
    xact_t x;
    x.we = 1'b1; x.addr = a & 32'hFFFF_FFF8; x.size = 2'd3;
    x.mask = 8'hFF; x.wdata = d; x.id = 4'd2;
    return x;
  endfunction

  function automatic xact_t uc_x(input logic we, input logic [31:0] a,
                                 input logic [1:0] s, input logic [7:0] m,
                                 input logic [63:0] d);
    xact_t x;
    x.we = we; x.addr = a; x.size = s;
    x.mask = m; x.wdata = d; x.id = 4'd3;
    return x;
  endfunction

  // Bridge responder: wait for the grant, check fields, optionally send a
  // stray ready with a foreign id, then complete with rd.
  task automatic serve(input string tag, input xact_t x,
                       input logic [63:0] rd, input bit bad);
    int n = 0;
    while (rw_valid_o !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_grant"}, rw_valid_o, 1);
    chk({tag, "_id"}, rw_id_o, x.id);
    chk({tag, "_req"}, rw_req_o, x.we);
    chk({tag, "_addr"}, rw_addr_o, x.addr);
    chk({tag, "_size"}, rw_size_o, x.size);
    chk({tag, "_mask"}, w_mask_o, x.mask);
    if (x.we) chk({tag, "_wdata"}, data_write_o, x.wdata);
    repeat ($urandom_range(0, 2)) begin
      tick;
      chk({tag, "_hold"}, rw_valid_o, 1);
      chk({tag, "_hold_addr"}, rw_addr_o, x.addr);
    end
    if (bad) begin
      rw_ready_i = 1'b1;
      rw_id_i = (x.id == 4'd1) ? 4'd3 : 4'd1;
      data_read_i = rnd64();
      tick;
      rw_ready_i = 1'b0;
      chk({tag, "_badid_valid"}, rw_valid_o, 1);
      chk({tag, "_badid_addr"}, rw_addr_o, x.addr);
    end
    rw_ready_i = 1'b1;
    rw_id_i = x.id;
    data_read_i = rd;
    tick;
    rw_ready_i = 1'b0;
    rw_id_i = 4'd0;
    data_read_i = rnd64();
  endtask

  task automatic chk_done(input string tag, input int owner,
                          input logic [63:0] rdata);
    chk({tag, "_valid_low"}, rw_valid_o, 0);
    chk({tag, "_ic_done"}, ic_done_o, owner == 1);
    chk({tag, "_dc_done"}, dc_done_o, owner == 2);
    chk({tag, "_uc_done"}, uc_done_o, owner == 3);
    if (owner == 1) chk({tag, "_ic_rdata"}, ic_rdata_o, rdata);
    if (owner == 2) chk({tag, "_dc_rdata"}, dc_rdata_o, rdata);
    if (owner == 3) chk({tag, "_uc_rdata"}, uc_rdata_o, rdata);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ic_done0"}, ic_done_o, 0);
    chk({tag, "_dc_done0"}, dc_done_o, 0);
    chk({tag, "_uc_done0"}, uc_done_o, 0);
    chk({tag, "_stall0"}, stall_o, 0);
  endtask

  task automatic run_single(input int kind);
    logic [63:0] rd;
    logic we;
    rd = rnd64();
    if (kind == 0) begin
      ic_addr_i = $urandom;
      ic_req_i = 1'b1;
      serve("r_ic", line_rd(ic_addr_i, 4'd1), rd, 1'($urandom_range(0, 1)));
      chk_done("r_ic", 1, rd);
      ic_req_i = 1'b0;
    end else if (kind == 1) begin
      dc_addr_i = $urandom;
      dc_vaddr_i = $urandom;
      dc_wbdata_i = rnd64();
      dc_dirty_i = 1'($urandom_range(0, 1));
      dc_req_i = 1'b1;
      if (dc_dirty_i) begin
        serve("r_wb", line_wb(dc_vaddr_i, dc_wbdata_i), rnd64(), 1'b0);
        chk("r_wb_nodone", dc_done_o, 0);
      end
      serve("r_dc", line_rd(dc_addr_i, 4'd2), rd, 1'($urandom_range(0, 1)));
      chk_done("r_dc", 2, rd);
      dc_req_i = 1'b0;
    end else begin
      we = 1'($urandom_range(0, 1));
      uc_we_i = we;
      uc_addr_i = $urandom;
      uc_size_i = 2'($urandom_range(0, 3));
      uc_mask_i = 8'($urandom);
      uc_wdata_i = rnd64();
      uc_req_i = 1'b1;
      serve("r_uc", uc_x(we, uc_addr_i, uc_size_i, uc_mask_i, uc_wdata_i),
            rd, 1'($urandom_range(0, 1)));
      chk_done("r_uc", 3, we ? 64'd0 : rd);
      uc_req_i = 1'b0;
    end
    tick;
    chk_quiet("r_after");
  endtask

  initial begin
    int cnt;
    int round;
    int ic_round;
    int exp_round;
    bit guard;

    reset = 1'b1;
    ic_req_i = 0; ic_addr_i = 0;
    dc_req_i = 0; dc_dirty_i = 0; dc_addr_i = 0;
    dc_vaddr_i = 0; dc_wbdata_i = 0;
    uc_req_i = 0; uc_we_i = 0; uc_addr_i = 0;
    uc_size_i = 0; uc_mask_i = 0; uc_wdata_i = 0;
    rw_ready_i = 0; rw_id_i = 0; data_read_i = 0;
    repeat (3) tick;
    chk("rst_valid", rw_valid_o, 0);
    chk("rst_addr", rw_addr_o, 0);
    chk("rst_id", rw_id_o, 0);
    chk("rst_mask", w_mask_o, 0);
    chk("rst_ic_rdata", ic_rdata_o, 0);
    chk("rst_dc_rdata", dc_rdata_o, 0);
    chk("rst_uc_rdata", uc_rdata_o, 0);
    chk_quiet("rst");
    @(negedge clock);
    reset = 1'b0;
    tick;

    // icache line refill
    ic_addr_i = 32'h8000_0004;
    ic_req_i = 1'b1;
    serve("t1", line_rd(32'h8000_0000, 4'd1), 64'h1122334455667788, 1'b0);
    chk_done("t1", 1, 64'h1122334455667788);
    ic_req_i = 1'b0;
    tick;
    chk_quiet("t1_after");

    // dirty dcache miss: writeback then refill
    dc_addr_i = 32'h8000_2000;
    dc_vaddr_i = 32'h8000_1008;
    dc_wbdata_i = 64'hAA;
    dc_dirty_i = 1'b1;
    dc_req_i = 1'b1;
    serve("t2_wb", line_wb(32'h8000_1008, 64'hAA), 64'h0, 1'b0);
    chk("t2_wb_nodone", dc_done_o, 0);
    chk("t2_wb_stall", stall_o, 1);
    serve("t2_rd", line_rd(32'h8000_2000, 4'd2), 64'hDEAD_BEEF, 1'b0);
    chk_done("t2", 2, 64'hDEAD_BEEF);
    dc_req_i = 1'b0;
    dc_dirty_i = 1'b0;
    tick;
    chk_quiet("t2_after");

    // simultaneous requests resolved dc, uc, ic
    dc_addr_i = 32'h8000_3010;
    uc_we_i = 1'b0;
    uc_addr_i = 32'hA000_0100;
    uc_size_i = 2'd2;
    uc_mask_i = 8'h0F;
    uc_wdata_i = 64'h0;
    ic_addr_i = 32'h8000_4020;
    dc_req_i = 1'b1;
    uc_req_i = 1'b1;
    ic_req_i = 1'b1;
    serve("t3_dc", line_rd(dc_addr_i, 4'd2), 64'h3, 1'b0);
    chk_done("t3_dc", 2, 64'h3);
    chk("t3_stall_a", stall_o, 1);
    dc_req_i = 1'b0;
    serve("t3_uc", uc_x(0, 32'hA000_0100, 2'd2, 8'h0F, 0), 64'h5, 1'b0);
    chk_done("t3_uc", 3, 64'h5);
    chk("t3_stall_b", stall_o, 1);
    uc_req_i = 1'b0;
    serve("t3_ic", line_rd(ic_addr_i, 4'd1), 64'h7, 1'b0);
    chk_done("t3_ic", 1, 64'h7);
    chk("t3_stall_c", stall_o, 0);
    ic_req_i = 1'b0;
    tick;
    chk_quiet("t3_after");

    // uncached byte write with a stray foreign-id ready
    uc_we_i = 1'b1;
    uc_addr_i = 32'hA000_03F8;
    uc_size_i = 2'd0;
    uc_mask_i = 8'h01;
    uc_wdata_i = 64'h41;
    uc_req_i = 1'b1;
    serve("t4", uc_x(1, 32'hA000_03F8, 2'd0, 8'h01, 64'h41),
          64'h99, 1'b1);
    chk_done("t4", 3, 64'h0);
    uc_req_i = 1'b0;
    tick;
    chk_quiet("t4_after");

    // reset mid-read, then reissue
    ic_addr_i = 32'h8000_5008;
    ic_req_i = 1'b1;
    tick;
    chk("t5_rd_valid", rw_valid_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_abort_valid", rw_valid_o, 0);
    chk("t5_abort_done", ic_done_o, 0);
    tick;
    chk("t5_rst_done", ic_done_o, 0);
    @(negedge clock);
    reset = 1'b0;
    serve("t5_re", line_rd(32'h8000_5008, 4'd1), 64'h55, 1'b0);
    chk_done("t5", 1, 64'h55);
    ic_req_i = 1'b0;
    tick;
    chk_quiet("t5_after");

    // dc re-requests continuously while ic waits
`ifdef RW_SCHED_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    exp_round = -1;
    cnt = 0;
    for (int r = 0; r < 8; r++) begin
      if (guard && cnt == 2 && exp_round < 0) exp_round = r;
      else if (!(guard && exp_round >= 0)) cnt++;
    end
    if (exp_round < 0) exp_round = 5;
    ic_addr_i = 32'h8000_6000;
    ic_req_i = 1'b1;
    dc_dirty_i = 1'b0;
    dc_addr_i = 32'h8000_7000;
    dc_req_i = 1'b1;
    ic_round = -1;
    round = 0;
    while (ic_round < 0 && round < 5) begin
      if (round == exp_round) begin
        serve("t6_ic", line_rd(ic_addr_i, 4'd1), 64'h66, 1'b0);
        chk_done("t6_ic", 1, 64'h66);
        ic_round = round;
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
      end else begin
        serve("t6_dc", line_rd(dc_addr_i, 4'd2), 64'(round), 1'b0);
        chk_done("t6_dc", 2, 64'(round));
        chk("t6_stall", stall_o, 1);
        dc_addr_i = dc_addr_i + 32'h40;
        if (round == 4) dc_req_i = 1'b0;
      end
      round++;
    end
    if (ic_round < 0) begin
      serve("t6_ic_late", line_rd(ic_addr_i, 4'd1), 64'h67, 1'b0);
      chk_done("t6_ic_late", 1, 64'h67);
      ic_round = round;
      ic_req_i = 1'b0;
    end
    chk("t6_ic_round", 64'(ic_round), 64'(exp_round));
    tick;
    chk_quiet("t6_after");

    for (int i = 0; i < 24; i++) run_single($urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
